vlc_feed_arbiter: RTL and testbench

- Shares the single serial input of the VLC core (data_in / din_valid) between NUM_REQ word-parallel producers.
- Arbitrates round-robin at frame granularity and serializes each accepted word MSB-first, one bit per clk.
- Inserts a fixed idle gap between frames so the VLC sees frame boundaries.
- Sits between the producer-side word sources and the VLC input; also reports status.

---
 rtl/vlc_pkg.sv | 22 ++
 rtl/vlc_rr_arbiter.sv | 37 +++
 rtl/vlc_feed_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_vlc_feed_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// Shared types and width helpers for the VLC serial feed arbiter.
//   state_t  : feed FSM states
//   cnt_w()  : counter width able to index 0..n-1 (never below 1 bit)
//   gap_last(): terminal value of the gap counter (0 when the gap is disabled)
package vlc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2,
    GAP   = 2'd3
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned gap_last(input int unsigned g);
    return (g == 0) ? 0 : g - 1;
  endfunction

endpackage

// File: rtl/vlc_rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// ptr, wrapping around.
//   req    : request vector
//   ptr    : index of the previous winner
//   gnt_c  : one-hot grant
//   idx_c  : index of the granted request
//   any_c  : at least one request asserted
module vlc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1 .. ptr+NUM_REQ modulo NUM_REQ; first hit wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!any_c && req[cand]) begin
        any_c       = 1'b1;
        idx_c       = cand;
        gnt_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vlc_feed_arbiter.sv
// Shares the VLC serial input between NUM_REQ word-parallel producers.
// Frames are granted round-robin, words are serialized MSB-first one bit
// per clock, and a fixed idle gap follows every frame.
//   clk, rst     : clock, synchronous active-low reset
//   req_valid    : per-requester word valid
//   req_data     : per-requester word, requester i at [i*WORD_W +: WORD_W]
//   req_last     : per-requester final-word-of-frame flag
//   req_ready    : combinational accept (at most one bit set)
//   data_in      : serial bit to the VLC (registered)
//   din_valid    : serial bit valid (registered)
//   grant_id     : current/last granted requester
//   busy         : FSM is in SHIFT, STALL or GAP
//   frames_done  : completed frame counter, wraps silently
module vlc_feed_arbiter
  import vlc_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        data_in,
  output logic                        din_valid,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [CNT_W-1:0]            frames_done
);

  localparam int unsigned IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned BIT_W    = cnt_w(WORD_W);
  localparam int unsigned BIT_LAST = WORD_W - 1;
  localparam int unsigned GAP_W    = cnt_w(GAP_CYCLES);
  localparam int unsigned GAP_LAST = gap_last(GAP_CYCLES);

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  shreg, shreg_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic               last_q, last_nxt;
  logic [IDX_W-1:0]   grant_q, grant_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic               data_q, data_nxt;
  logic               dvalid_q, dvalid_nxt;
  logic               busy_q;
  logic [CNT_W-1:0]   frames_q, frames_nxt;

  logic [NUM_REQ-1:0] ready_c;
  logic               load_c;
  logic [IDX_W-1:0]   sel_c;
  logic [WORD_W-1:0]  word_c;
  logic               word_last_c;

  logic [NUM_REQ-1:0] arb_gnt_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_any_c;

  vlc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c),
    .any_c (arb_any_c)
  );

  // Word source: arbiter winner when idle, otherwise the frame owner.
  assign sel_c       = (state == IDLE) ? arb_idx_c : grant_q;
  assign word_c      = req_data[32'(sel_c)*WORD_W +: WORD_W];
  assign word_last_c = req_last[sel_c];

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    last_nxt    = last_q;
    grant_nxt   = grant_q;
    rr_ptr_nxt  = rr_ptr;
    frames_nxt  = frames_q;
    data_nxt    = 1'b0;
    dvalid_nxt  = 1'b0;
    ready_c     = '0;
    load_c      = 1'b0;

    case (state)
      IDLE: begin
        if (arb_any_c) begin
          ready_c    = arb_gnt_c;
          load_c     = 1'b1;
          grant_nxt  = arb_idx_c;
          rr_ptr_nxt = arb_idx_c;
        end
      end

      SHIFT: begin
        if (bit_cnt == BIT_W'(BIT_LAST)) begin
          // Final bit on the wire: finish the frame, chain the next word,
          // or wait for the owner.
          if (last_q) begin
            frames_nxt = frames_q + CNT_W'(1);
            if (GAP_CYCLES == 0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt   = GAP;
              gap_cnt_nxt = '0;
            end
          end else if (req_valid[grant_q]) begin
            ready_c[grant_q] = 1'b1;
            load_c           = 1'b1;
          end else begin
            state_nxt = STALL;
          end
        end else begin
          dvalid_nxt  = 1'b1;
          data_nxt    = shreg[WORD_W-1];
          shreg_nxt   = shreg << 1;
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end

      STALL: begin
        if (req_valid[grant_q]) begin
          ready_c[grant_q] = 1'b1;
          load_c           = 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Accepted word: MSB goes straight to the output register, the rest
    // waits in the shifter.
    if (load_c) begin
      data_nxt    = word_c[WORD_W-1];
      dvalid_nxt  = 1'b1;
      shreg_nxt   = word_c << 1;
      last_nxt    = word_last_c;
      bit_cnt_nxt = '0;
      state_nxt   = SHIFT;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      last_q   <= 1'b0;
      grant_q  <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      data_q   <= 1'b0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      last_q   <= last_nxt;
      grant_q  <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      data_q   <= data_nxt;
      dvalid_q <= dvalid_nxt;
      busy_q   <= (state_nxt != IDLE);
      frames_q <= frames_nxt;
    end
  end

  // No handshake may complete while reset is being sampled.
  assign req_ready   = rst ? ready_c : '0;
  assign data_in     = data_q;
  assign din_valid   = dvalid_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_vlc_feed_arbiter.sv
// Directed bench for vlc_feed_arbiter (2 requesters, 8-bit words,
// 2-cycle gap, 4-bit frame counter so the wrap is reachable).
module tb_vlc_feed_arbiter;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned WORD_W     = 8;
  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned CNT_W      = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      data_in;
  logic                      din_valid;
  logic [0:0]                grant_id;
  logic                      busy;
  logic [CNT_W-1:0]          frames_done;

  int n_cmp;
  int n_err;

  vlc_feed_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WORD_W     (WORD_W),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .data_in     (data_in),
    .din_valid   (din_valid),
    .grant_id    (grant_id),
    .busy        (busy),
    .frames_done (frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]          = v;
    req_data[i*WORD_W +: WORD_W] = d;
    req_last[i]           = l;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Called in the first bit cycle; returns in the cycle after the last bit.
  task automatic expect_word(input string tag, input logic [7:0] w, input logic [1:0] rdy_last);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("%s_dv%0d", tag, b), 32'(din_valid), 32'd1);
      chk($sformatf("%s_bit%0d", tag, b), 32'(data_in), 32'(w[7-b]));
      chk($sformatf("%s_rdy%0d", tag, b), 32'(req_ready), (b == 7) ? 32'(rdy_last) : 32'd0);
      chk($sformatf("%s_busy%0d", tag, b), 32'(busy), 32'd1);
      tick();
    end
  endtask

  // Called in the first gap cycle; returns in the following IDLE cycle.
  task automatic gap_check(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_dv%0d", tag, g), 32'(din_valid), 32'd0);
      chk($sformatf("%s_din%0d", tag, g), 32'(data_in), 32'd0);
      chk($sformatf("%s_rdy%0d", tag, g), 32'(req_ready), 32'd0);
      chk($sformatf("%s_busy%0d", tag, g), 32'(busy), 32'd1);
      tick();
    end
    chk($sformatf("%s_idle", tag), 32'(busy), 32'd0);
  endtask

  // One single-word frame from requester 0, started and ended in IDLE.
  task automatic do_frame(input string tag);
    set_req(0, 1'b1, 8'h11, 1'b1);
    #1;
    chk($sformatf("%s_rdy", tag), 32'(req_ready), 32'd1);
    tick();
    set_req(0, 1'b0, 8'h11, 1'b1);
    repeat (10) tick();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    req_valid = 2'b11;
    req_data  = 16'h1234;
    req_last  = 2'b11;

    // Reset values, with requests pending while reset is held
    tick();
    tick();
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_dv", 32'(din_valid), 32'd0);
    chk("rst_din", 32'(data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_frames", 32'(frames_done), 32'd0);
    req_valid = '0;
    rst = 1'b1;

    // T1: req0 sends A5 as a one-word frame
    set_req(0, 1'b1, 8'hA5, 1'b1);
    #1;
    chk("t1_rdy", 32'(req_ready), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    chk("t1_gid", 32'(grant_id), 32'd0);
    expect_word("t1", 8'hA5, 2'b00);
    gap_check("t1_gap");
    chk("t1_frames", 32'(frames_done), 32'd1);

    // T2: both requesters, one-word frames, grant order 0,1,0
    do_reset();
    chk("t2_frames0", 32'(frames_done), 32'd0);
    set_req(0, 1'b1, 8'h3C, 1'b1);
    set_req(1, 1'b1, 8'hC3, 1'b1);
    #1;
    chk("t2_rdy_a", 32'(req_ready), 32'd1);
    tick();
    chk("t2_gid_a", 32'(grant_id), 32'd0);
    expect_word("t2a", 8'h3C, 2'b00);
    gap_check("t2a_gap");
    #1;
    chk("t2_rdy_b", 32'(req_ready), 32'd2);
    tick();
    chk("t2_gid_b", 32'(grant_id), 32'd1);
    expect_word("t2b", 8'hC3, 2'b00);
    gap_check("t2b_gap");
    #1;
    chk("t2_rdy_c", 32'(req_ready), 32'd1);
    tick();
    chk("t2_gid_c", 32'(grant_id), 32'd0);
    set_req(0, 1'b0, 8'h3C, 1'b1);
    set_req(1, 1'b0, 8'hC3, 1'b1);
    expect_word("t2c", 8'h3C, 2'b00);
    gap_check("t2c_gap");
    chk("t2_frames", 32'(frames_done), 32'd3);

    // T3: req1 two-word frame FF, 00(last), back to back
    set_req(1, 1'b1, 8'hFF, 1'b0);
    #1;
    chk("t3_rdy", 32'(req_ready), 32'd2);
    tick();
    chk("t3_gid", 32'(grant_id), 32'd1);
    set_req(1, 1'b1, 8'h00, 1'b1);
    expect_word("t3a", 8'hFF, 2'b10);
    set_req(1, 1'b0, 8'h00, 1'b1);
    expect_word("t3b", 8'h00, 2'b00);
    gap_check("t3_gap");
    chk("t3_frames", 32'(frames_done), 32'd4);

    // T4: req0 stalls 3 cycles mid-frame; req1 waits throughout
    set_req(0, 1'b1, 8'h96, 1'b0);
    set_req(1, 1'b1, 8'h81, 1'b1);
    #1;
    chk("t4_rdy", 32'(req_ready), 32'd1);
    tick();
    chk("t4_gid", 32'(grant_id), 32'd0);
    set_req(0, 1'b0, 8'h96, 1'b0);
    expect_word("t4a", 8'h96, 2'b00);
    for (int s = 0; s < 3; s++) begin
      if (s == 2) begin
        set_req(0, 1'b1, 8'h5A, 1'b1);
        #1;
      end
      chk($sformatf("t4_stall_dv%0d", s), 32'(din_valid), 32'd0);
      chk($sformatf("t4_stall_din%0d", s), 32'(data_in), 32'd0);
      chk($sformatf("t4_stall_busy%0d", s), 32'(busy), 32'd1);
      chk($sformatf("t4_stall_gid%0d", s), 32'(grant_id), 32'd0);
      chk($sformatf("t4_stall_rdy%0d", s), 32'(req_ready), (s == 2) ? 32'd1 : 32'd0);
      tick();
    end
    set_req(0, 1'b0, 8'h5A, 1'b1);
    set_req(1, 1'b0, 8'h81, 1'b1);
    chk("t4_gid_b", 32'(grant_id), 32'd0);
    expect_word("t4b", 8'h5A, 2'b00);
    gap_check("t4_gap");
    chk("t4_frames", 32'(frames_done), 32'd5);

    // T5: reset during bit 4 of a req0 frame
    do_reset();
    set_req(0, 1'b1, 8'hF0, 1'b1);
    #1;
    tick();
    set_req(0, 1'b0, 8'hF0, 1'b1);
    repeat (4) tick();
    chk("t5_bit4_dv", 32'(din_valid), 32'd1);
    chk("t5_bit4", 32'(data_in), 32'd0);
    rst = 1'b0;
    set_req(0, 1'b1, 8'hF0, 1'b1);
    set_req(1, 1'b1, 8'h0F, 1'b1);
    tick();
    chk("t5_dv", 32'(din_valid), 32'd0);
    chk("t5_din", 32'(data_in), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_frames", 32'(frames_done), 32'd0);
    chk("t5_gid", 32'(grant_id), 32'd0);
    #1;
    chk("t5_rdy_rst", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rdy", 32'(req_ready), 32'd1);
    tick();
    chk("t5_gid_post", 32'(grant_id), 32'd0);
    set_req(0, 1'b0, 8'hF0, 1'b1);
    set_req(1, 1'b0, 8'h0F, 1'b1);
    expect_word("t5", 8'hF0, 2'b00);
    gap_check("t5_gap");
    chk("t5_frames_post", 32'(frames_done), 32'd1);

    // T6: frame counter wraps 15 -> 0
    for (int f = 0; f < 14; f++) begin
      do_frame($sformatf("t6_f%0d", f));
    end
    chk("t6_frames_max", 32'(frames_done), 32'd15);
    do_frame("t6_wrap");
    chk("t6_frames_wrap", 32'(frames_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
